// File: rtl/alu_result_writeback.sv
// Execute-stage return path: 2-entry skid FIFO draining ALU results to the
// register file write port, with forwarding of not-yet-written results.
module alu_result_writeback #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_result,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic                  in_wen,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0]     wb_data,
   input  logic [REG_ADDR_W-1:0] fwd_rs_a,
   input  logic [REG_ADDR_W-1:0] fwd_rs_b,
   output logic                  fwd_hit_a,
   output logic                  fwd_hit_b,
   output logic [DATA_W-1:0]     fwd_data_a,
   output logic [DATA_W-1:0]     fwd_data_b
);

   logic [REG_ADDR_W-1:0] r_rd   [2];
   logic [DATA_W-1:0]     r_data [2];
   logic                  r_head;
   logic                  r_tail;
   logic [1:0]            r_count;

   logic                  w_accept;
   logic                  w_store;
   logic                  w_pop;
   logic                  w_young;
   logic                  w_has_young;
   logic                  w_has_old;
   logic [REG_ADDR_W-1:0] w_rs   [2];
   logic                  w_hit  [2];
   logic [DATA_W-1:0]     w_fdat [2];

   assign in_ready = (r_count != 2'd2);
   assign wb_valid = (r_count != 2'd0);

   assign w_accept = in_valid & in_ready;
   // Beats that write nothing (no wen, or x0) are consumed without storage.
   assign w_store  = w_accept & in_wen & (in_rd != '0);
   assign w_pop    = wb_valid & wb_ready;

   assign wb_addr = wb_valid ? r_rd[r_head]   : '0;
   assign wb_data = wb_valid ? r_data[r_head] : '0;

   assign w_young     = ~r_tail;
   assign w_has_young = (r_count != 2'd0);
   assign w_has_old   = (r_count == 2'd2);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_count <= 2'd0;
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
      end else begin
         if (w_store) begin
            r_tail <= ~r_tail;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         unique case ({w_store, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload needs no reset: every read of it is qualified by r_count.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && w_store) begin
         r_rd[r_tail]   <= in_rd;
         r_data[r_tail] <= in_result;
      end
   end

   assign w_rs[0] = fwd_rs_a;
   assign w_rs[1] = fwd_rs_b;

   always_comb begin
      for (int l = 0; l < 2; l++) begin
         w_hit[l]  = 1'b0;
         w_fdat[l] = '0;
         if (w_rs[l] != '0) begin
            if (w_has_old && r_rd[r_head] == w_rs[l]) begin
               w_hit[l]  = 1'b1;
               w_fdat[l] = r_data[r_head];
            end
            // Youngest entry overrides the older match.
            if (w_has_young && r_rd[w_young] == w_rs[l]) begin
               w_hit[l]  = 1'b1;
               w_fdat[l] = r_data[w_young];
            end
         end
      end
   end

   assign fwd_hit_a  = w_hit[0];
   assign fwd_hit_b  = w_hit[1];
   assign fwd_data_a = w_fdat[0];
   assign fwd_data_b = w_fdat[1];

endmodule

// File: tb/tb_alu_result_writeback.sv
// Bench for alu_result_writeback: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_alu_result_writeback;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [4:0]  fwd_rs_a;
   logic [4:0]  fwd_rs_b;
   logic        fwd_hit_a;
   logic        fwd_hit_b;
   logic [31:0] fwd_data_a;
   logic [31:0] fwd_data_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   ent_t q[$];

   alu_result_writeback #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_rd(in_rd), .in_wen(in_wen),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_addr(wb_addr), .wb_data(wb_data),
      .fwd_rs_a(fwd_rs_a), .fwd_rs_b(fwd_rs_b),
      .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
      .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a plain queue of pending writes, oldest first.
   task automatic m_update();
      bit pop;
      bit push;
      if (!rst_n || flush) begin
         q.delete();
         return;
      end
      pop  = (q.size() != 0) && wb_ready;
      push = in_valid && (q.size() < 2) && in_wen && (in_rd != 5'd0);
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{in_rd, in_result});
   endtask

   function automatic void m_fwd(input logic [4:0] rs,
                                 output logic h, output logic [31:0] d);
      h = 1'b0;
      d = 32'd0;
      if (rs == 5'd0) return;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].rd == rs) begin
            h = 1'b1;
            d = q[i].d;
            return;
         end
      end
   endfunction

   task automatic tick();
      m_update();
      @(posedge clk);
      #1;
   endtask

   task automatic push_in(input logic [4:0] rd, input logic [31:0] d,
                          input logic wen);
      in_valid  = 1'b1;
      in_rd     = rd;
      in_result = d;
      in_wen    = wen;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      checks++;
      if ({wb_valid, wb_addr, wb_data} !== 38'd0) begin
         errors++;
         $display("FAIL reset_wb got %b/%h/%h want 0", wb_valid, wb_addr, wb_data);
      end
      checks++;
      if ({fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b} !== 66'd0) begin
         errors++;
         $display("FAIL reset_fwd got %b%b/%h/%h want 0",
                  fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b);
      end
   endtask

   task automatic test_basic();
      wb_ready = 1'b1;
      push_in(5'd5, 32'hDEADBEEF, 1'b1);
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL basic_wb got %b/%h/%h want 1/05/deadbeef",
                  wb_valid, wb_addr, wb_data);
      end
      tick();
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_drained got %b want 0", wb_valid);
      end
   endtask

   task automatic test_order();
      wb_ready = 1'b0;
      push_in(5'd3, 32'h11, 1'b1);
      tick();
      push_in(5'd3, 32'h22, 1'b1);
      tick();
      in_valid = 1'b0;
      fwd_rs_a = 5'd3;
      fwd_rs_b = 5'd3;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL order_full got %b want 0", in_ready);
      end
      checks++;
      if ({fwd_hit_a, fwd_data_a} !== {1'b1, 32'h22}) begin
         errors++;
         $display("FAIL order_fwd_a got %b/%h want 1/22", fwd_hit_a, fwd_data_a);
      end
      checks++;
      if ({fwd_hit_b, fwd_data_b} !== {1'b1, 32'h22}) begin
         errors++;
         $display("FAIL order_fwd_b got %b/%h want 1/22", fwd_hit_b, fwd_data_b);
      end
      tick();
      checks++;
      if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd3, 32'h11}) begin
         errors++;
         $display("FAIL order_hold got %b/%h/%h want 1/03/11",
                  wb_valid, wb_addr, wb_data);
      end
      wb_ready = 1'b1;
      tick();
      checks++;
      if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd3, 32'h22}) begin
         errors++;
         $display("FAIL order_second got %b/%h/%h want 1/03/22",
                  wb_valid, wb_addr, wb_data);
      end
      tick();
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL order_empty got %b want 0", wb_valid);
      end
   endtask

   task automatic test_drop();
      wb_ready = 1'b1;
      push_in(5'd0, 32'h55, 1'b1);
      tick();
      push_in(5'd7, 32'h77, 1'b0);
      tick();
      in_valid = 1'b0;
      fwd_rs_a = 5'd0;
      fwd_rs_b = 5'd7;
      #1;
      checks++;
      if ({wb_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL drop_state got %b%b want 01", wb_valid, in_ready);
      end
      checks++;
      if ({fwd_hit_a, fwd_hit_b} !== 2'b00) begin
         errors++;
         $display("FAIL drop_fwd got %b%b want 00", fwd_hit_a, fwd_hit_b);
      end
   endtask

   task automatic test_push_pop();
      wb_ready = 1'b0;
      push_in(5'd2, 32'hA, 1'b1);
      tick();
      wb_ready = 1'b1;
      push_in(5'd4, 32'hB, 1'b1);
      fwd_rs_a = 5'd2;
      #1;
      checks++;
      if ({fwd_hit_a, fwd_data_a} !== {1'b1, 32'hA}) begin
         errors++;
         $display("FAIL pp_popping_hit got %b/%h want 1/a", fwd_hit_a, fwd_data_a);
      end
      tick();
      in_valid = 1'b0;
      wb_ready = 1'b0;
      #1;
      checks++;
      if ({wb_valid, in_ready, wb_addr, wb_data} !== {2'b11, 5'd4, 32'hB}) begin
         errors++;
         $display("FAIL pp_head got %b%b/%h/%h want 11/04/b",
                  wb_valid, in_ready, wb_addr, wb_data);
      end
      wb_ready = 1'b1;
      tick();
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL pp_drain got %b want 0", wb_valid);
      end
   endtask

   task automatic test_flush();
      wb_ready = 1'b0;
      push_in(5'd6, 32'h61, 1'b1);
      tick();
      push_in(5'd6, 32'h62, 1'b1);
      tick();
      flush = 1'b1;
      push_in(5'd6, 32'h63, 1'b1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      fwd_rs_a = 5'd6;
      fwd_rs_b = 5'd6;
      #1;
      checks++;
      if ({wb_valid, in_ready, fwd_hit_a, fwd_hit_b} !== 4'b0100) begin
         errors++;
         $display("FAIL flush_full got %b%b%b%b want 0100",
                  wb_valid, in_ready, fwd_hit_a, fwd_hit_b);
      end
      // Flush at count=1 with an acceptable beat: that beat is dropped too.
      push_in(5'd6, 32'h64, 1'b1);
      tick();
      flush = 1'b1;
      push_in(5'd9, 32'h99, 1'b1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      fwd_rs_b = 5'd9;
      #1;
      checks++;
      if ({wb_valid, in_ready, fwd_hit_a, fwd_hit_b} !== 4'b0100) begin
         errors++;
         $display("FAIL flush_one got %b%b%b%b want 0100",
                  wb_valid, in_ready, fwd_hit_a, fwd_hit_b);
      end
   endtask

   task automatic test_reset_mid();
      wb_ready = 1'b0;
      push_in(5'd8, 32'h81, 1'b1);
      tick();
      push_in(5'd9, 32'h91, 1'b1);
      tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      fwd_rs_a = 5'd8;
      fwd_rs_b = 5'd9;
      #1;
      checks++;
      if ({wb_valid, wb_addr, wb_data, in_ready} !== {38'd0, 1'b1}) begin
         errors++;
         $display("FAIL rstmid_out got %b/%h/%h/%b want 0/0/0/1",
                  wb_valid, wb_addr, wb_data, in_ready);
      end
      checks++;
      if ({fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b} !== 66'd0) begin
         errors++;
         $display("FAIL rstmid_fwd got %b%b/%h/%h want 0",
                  fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b);
      end
      wb_ready = 1'b1;
      tick();
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_nowrite got %b want 0", wb_valid);
      end
   endtask

   task automatic test_random();
      logic        eh_a;
      logic        eh_b;
      logic [31:0] ed_a;
      logic [31:0] ed_b;
      logic        e_val;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      for (int n = 0; n < 600; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_rd     = 5'($urandom_range(0, 7));
         in_result = $urandom;
         in_wen    = ($urandom_range(0, 5) != 0);
         wb_ready  = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         rst_n     = ($urandom_range(0, 60) != 0);
         fwd_rs_a  = 5'($urandom_range(0, 7));
         fwd_rs_b  = 5'($urandom_range(0, 7));
         #1;
         e_val  = (q.size() != 0);
         e_addr = e_val ? q[0].rd : 5'd0;
         e_data = e_val ? q[0].d : 32'd0;
         m_fwd(fwd_rs_a, eh_a, ed_a);
         m_fwd(fwd_rs_b, eh_b, ed_b);
         checks++;
         if (in_ready !== (q.size() != 2)) begin
            errors++;
            $display("FAIL rnd_ready n=%0d got %b want %b", n, in_ready, q.size() != 2);
         end
         checks++;
         if ({wb_valid, wb_addr, wb_data} !== {e_val, e_addr, e_data}) begin
            errors++;
            $display("FAIL rnd_wb n=%0d got %b/%h/%h want %b/%h/%h",
                     n, wb_valid, wb_addr, wb_data, e_val, e_addr, e_data);
         end
         checks++;
         if ({fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b}
             !== {eh_a, ed_a, eh_b, ed_b}) begin
            errors++;
            $display("FAIL rnd_fwd n=%0d got %b/%h %b/%h want %b/%h %b/%h", n,
                     fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b,
                     eh_a, ed_a, eh_b, ed_b);
         end
         tick();
      end
      rst_n    = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_result = '0;
      in_rd     = '0;
      in_wen    = 1'b0;
      wb_ready  = 1'b0;
      fwd_rs_a  = '0;
      fwd_rs_b  = '0;
      #2;
      test_reset();
      test_basic();
      test_order();
      test_drop();
      test_push_pop();
      test_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
